hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

- Central pipeline controller for the 5-stage core.
- Drives the `en`, `stall` and `flush` inputs of the four pipeline registers: IF/ID, ID/EX, EX/MEM, MEM/WB.
- Drives the PC hold.
- Detects RAW hazards, branch redirects and multi-cycle data-memory waits.
- Sequences the post-reset pipeline fill.
- Keeps stall/flush performance counters.

## Interface
- `FILL_CYCLES`, 2: cycles `pipe_en` stays low after reset.
- `MEM_TIMEOUT`, 64: consecutive wait cycles before `mem_timeout` sets.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `id_rs1`, `id_rs2` in 5: ID-stage source registers.
- `id_rs1_used`, `id_rs2_used` in 1: source actually read.
- `ex_rs1`, `ex_rs2` in 5: EX-stage sources (forwarding only).
- `ex_rf_wa` in 5, `ex_rf_we` in 1, `ex_is_load` in 1: EX destination.
- `mem_rf_wa` in 5, `mem_rf_we` in 1: MEM destination.
- `wb_rf_wa` in 5, `wb_rf_we` in 1: WB destination.
- `ex_br_taken` in 1: EX resolved a taken branch or jump.
- `mem_req` in 1, `mem_ready` in 1: data-memory access in MEM and its completion.
- `pipe_en` out 1: common `en` to all pipeline registers.
- `pc_stall` out 1: hold the PC.
- `ifid_stall`, `idex_stall`, `exmem_stall`, `memwb_stall` out 1: per-register stall.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush` out 1: per-register flush.
- `fwd_rs1_sel`, `fwd_rs2_sel` out 2: operand source in EX.
  - 00 = register file
  - 01 = EX/MEM
  - 10 = MEM/WB
- `mem_timeout` out 1: sticky wait-timeout flag.
- `stall_cycles` out 32: count of cycles with `pc_stall` high.
- `flush_events` out 32: count of branch flushes.

## Operation
- FSM states: FILL, RUN, MEM_WAIT.
- FILL
  - `pipe_en` = 0.
  - A counter runs 0..`FILL_CYCLES`-1, then moves to RUN.
  - All stall and flush outputs are 0.
- RUN to MEM_WAIT: when `mem_req` && !`mem_ready`.
- MEM_WAIT to RUN: when `mem_ready`.
  - A wait counter increments each MEM_WAIT cycle.
  - The wait counter clears on exit.
  - When it reaches `MEM_TIMEOUT`, `mem_timeout` sets and stays set until `rst`.
  - The wait itself continues after timeout.
- Hazard match: source used, source ≠ x0, destination we=1, addresses equal.
- Priority, evaluated combinationally every cycle in RUN and MEM_WAIT:
  1. Memory wait (`mem_req` && !`mem_ready`):
     - `pc_stall`, `ifid_stall`, `idex_stall`, `exmem_stall` = 1.
     - `memwb_flush` = 1, to insert a bubble into WB.
     - All other flushes are 0.
  2. Branch (`ex_br_taken`):
     - `ifid_flush` = `idex_flush` = 1.
     - No stalls.
     - `flush_events` increments.
  3. RAW stall:
     - `pc_stall` = `ifid_stall` = 1.
     - `idex_flush` = 1.
- Branch during a memory wait: no flush while stalled.
  - EX is held, so `ex_br_taken` stays asserted.
  - The flush fires in the cycle `mem_ready` arrives.
- Branch with a simultaneous RAW: branch wins, because the hazarding ID instruction is discarded.
- `stall_cycles` and `flush_events` saturate at 32'hFFFF_FFFF.
- `rst` mid-operation forces FILL immediately and clears all counters and the flag.

## Timing
- All stall, flush and fwd outputs are combinational from the current state and inputs.
- The pipeline registers sample them at the same edge.
- `pipe_en`, `mem_timeout` and the counters are registered.
- Reset values:
  - `pipe_en` 0, `mem_timeout` 0, counters 0.
  - All stall, flush and fwd outputs 0.
  - State FILL.
- `pipe_en` rises exactly `FILL_CYCLES` rising edges after `rst` deasserts.
- A load-use hazard costs 1 bubble.
- A branch costs 2 bubbles.
- A memory wait costs one stall cycle per cycle with `mem_ready` low.
- Counters update at the edge that ends the counted cycle.

## Configuration
- Macro: `HAZARD_FWD_EN`.
- Defined:
  - RAW stall only when `ex_is_load` and the EX destination matches an ID source.
  - `fwd_rsN_sel` = 01 if EX/MEM matches `ex_rsN`, else 10 if MEM/WB matches, else 00.
  - EX/MEM has priority over MEM/WB.
- Undefined:
  - RAW stall whenever an ID source matches the EX, MEM or WB destination.
  - `fwd_rs1_sel`/`fwd_rs2_sel` are tied to 00.

## Structure
- Shared package `hazard_pkg` holds:
  - the state enum (FILL/RUN/MEM_WAIT);
  - the fwd select constants FWD_RF/FWD_EXMEM/FWD_MEMWB;
  - the x0 address constant.
- One sub-module `hazard_match`: combinational address/we/used comparator, instantiated per source/stage pair.

## Test plan
- Reset then release, `FILL_CYCLES`=2 -> `pipe_en`=0 for 2 edges, 1 on the third; no stall or flush during FILL.
- `lw x5` in EX (`ex_is_load`=1, `ex_rf_wa`=5), `id_rs1`=5 used -> exactly one cycle of `pc_stall`, `ifid_stall` and `idex_flush`; `stall_cycles`=1.
- `ex_br_taken`=1 together with a load-use hazard -> `ifid_flush`=`idex_flush`=1, no stall, `flush_events`=1.
- `mem_req`=1, `mem_ready` low 3 cycles while `ex_br_taken`=1 -> 3 cycles of stall plus `memwb_flush`, no ifid/idex flush; branch flush in cycle 4.
- `mem_ready` held low for 64 cycles -> `mem_timeout` rises after the 64th wait cycle and holds after `mem_ready`; cleared only by `rst`.
- `HAZARD_FWD_EN` defined, `ex_rs2`=7, `mem_rf_wa`=`wb_rf_wa`=7, both we=1 -> `fwd_rs2_sel`=01; same with `mem_rf_we`=0 -> 10; `ex_rs2`=0 -> 00.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam logic [4:0] X0 = 5'd0;

endpackage

// File: rtl/hazard_match.sv
// Register-address comparator: a source that is read hits a destination being written.
module hazard_match
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic       used,
  input  logic [4:0] dst,
  input  logic       we,
  output logic       hit
);

  assign hit = used && (src != X0) && we && (src == dst);

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush/forward controller for the 5-stage core.
// Define HAZARD_FWD_EN to enable EX operand forwarding (only load-use then stalls).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FILL_CYCLES = 2,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rf_wa,
  input  logic        ex_rf_we,
  input  logic        ex_is_load,
  input  logic [4:0]  mem_rf_wa,
  input  logic        mem_rf_we,
  input  logic [4:0]  wb_rf_wa,
  input  logic        wb_rf_we,
  input  logic        ex_br_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pipe_en,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_stall,
  output logic        exmem_stall,
  output logic        memwb_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic [1:0]  fwd_rs1_sel,
  output logic [1:0]  fwd_rs2_sel,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  localparam int FILL_W = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

`ifdef HAZARD_FWD_EN
  localparam int NDST = 1;
`else
  localparam int NDST = 3;
`endif

  state_t              state, state_nxt;
  logic [FILL_W-1:0]   fill_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [2*NDST-1:0]   raw_hit;
  logic                raw, mem_wait, active, br_flush;
  logic [1:0]          fwd1, fwd2;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // ID sources against EX (and, without forwarding, MEM and WB) destinations
  for (genvar i = 0; i < 2; i++) begin : g_src
    for (genvar j = 0; j < NDST; j++) begin : g_dst
      hazard_match u_match (
        .src  (i == 0 ? id_rs1 : id_rs2),
        .used (i == 0 ? id_rs1_used : id_rs2_used),
        .dst  (j == 0 ? ex_rf_wa : (j == 1 ? mem_rf_wa : wb_rf_wa)),
        .we   (j == 0 ? ex_rf_we : (j == 1 ? mem_rf_we : wb_rf_we)),
        .hit  (raw_hit[i*NDST+j])
      );
    end
  end

`ifdef HAZARD_FWD_EN
  logic [3:0] fwd_hit;

  function automatic logic [1:0] fwd_sel(input logic exmem_hit, input logic memwb_hit);
    if (exmem_hit) return FWD_EXMEM;
    if (memwb_hit) return FWD_MEMWB;
    return FWD_RF;
  endfunction

  for (genvar i = 0; i < 2; i++) begin : g_fsrc
    for (genvar j = 0; j < 2; j++) begin : g_fdst
      hazard_match u_fmatch (
        .src  (i == 0 ? ex_rs1 : ex_rs2),
        .used (1'b1),
        .dst  (j == 0 ? mem_rf_wa : wb_rf_wa),
        .we   (j == 0 ? mem_rf_we : wb_rf_we),
        .hit  (fwd_hit[i*2+j])
      );
    end
  end

  assign raw  = ex_is_load && (|raw_hit);
  assign fwd1 = fwd_sel(fwd_hit[0], fwd_hit[1]);
  assign fwd2 = fwd_sel(fwd_hit[2], fwd_hit[3]);
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_rs1, ex_rs2, ex_is_load};
  assign raw  = |raw_hit;
  assign fwd1 = FWD_RF;
  assign fwd2 = FWD_RF;
`endif

  assign active   = (state != FILL);
  assign mem_wait = mem_req && !mem_ready;
  // A branch seen while memory stalls is held in EX and flushes once the wait ends
  assign br_flush = active && !mem_wait && ex_br_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:     if (fill_cnt == FILL_W'(FILL_CYCLES - 1)) state_nxt = RUN;
      RUN:      if (mem_wait) state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_ready) state_nxt = RUN;
      default:  state_nxt = FILL;
    endcase
  end

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    memwb_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    fwd_rs1_sel = FWD_RF;
    fwd_rs2_sel = FWD_RF;
    if (active) begin
      fwd_rs1_sel = fwd1;
      fwd_rs2_sel = fwd2;
      if (mem_wait) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_flush = 1'b1;
      end else if (ex_br_taken) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
      end else if (raw) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_flush  = 1'b1;
      end
    end
  end

  // Registered control: fill sequencing, wait watchdog, performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_en      <= 1'b0;
      fill_cnt     <= '0;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      pipe_en  <= (state_nxt != FILL);
      fill_cnt <= (state == FILL) ? fill_cnt + 1'b1 : '0;
      if (active && mem_wait) begin
        if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (pc_stall) stall_cycles <= sat_inc(stall_cycles);
      if (br_flush) flush_events <= sat_inc(flush_events);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (fill, load-use, branch, memory wait, timeout, forwarding, reset).
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rf_wa, mem_rf_wa, wb_rf_wa;
  logic        id_rs1_used, id_rs2_used, ex_rf_we, ex_is_load, mem_rf_we, wb_rf_we;
  logic        ex_br_taken, mem_req, mem_ready;
  logic        pipe_en, pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_timeout;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic [31:0] stall_cycles, flush_events;

  // pattern bits: pc, ifid_s, idex_s, exmem_s, memwb_s, ifid_f, idex_f, exmem_f, memwb_f
  localparam logic [8:0] NONE = 9'b00000_0000;
  localparam logic [8:0] MEMW = 9'b11110_0001;
  localparam logic [8:0] BR   = 9'b00000_1100;
  localparam logic [8:0] RAW  = 9'b11000_0100;

  typedef struct {
    string       tag;
    logic [14:0] ctl;
    logic [31:0] sc;
    logic [31:0] fe;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sc_m = 0;
  logic [31:0] fe_m = 0;
  logic [14:0] ctl_obs;

  assign ctl_obs = {pipe_en, mem_timeout, pc_stall, ifid_stall, idex_stall, exmem_stall,
                    memwb_stall, ifid_flush, idex_flush, exmem_flush, memwb_flush,
                    fwd_rs1_sel, fwd_rs2_sel};

  hazard_ctrl #(.FILL_CYCLES(2), .MEM_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rf_wa(ex_rf_wa), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
    .mem_rf_wa(mem_rf_wa), .mem_rf_we(mem_rf_we), .wb_rf_wa(wb_rf_wa), .wb_rf_we(wb_rf_we),
    .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pipe_en(pipe_en), .pc_stall(pc_stall),
    .ifid_stall(ifid_stall), .idex_stall(idex_stall), .exmem_stall(exmem_stall), .memwb_stall(memwb_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic quiet();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rs1 = 5'd0; ex_rs2 = 5'd0;
    ex_rf_wa = 5'd0; ex_rf_we = 1'b0; ex_is_load = 1'b0;
    mem_rf_wa = 5'd0; mem_rf_we = 1'b0; wb_rf_wa = 5'd0; wb_rf_we = 1'b0;
    ex_br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    vectors++;
    assert (ctl_obs === e.ctl) else begin
      miscompares++;
      $error("FAIL %s ctl observed=%b expected=%b", e.tag, ctl_obs, e.ctl);
    end
    vectors++;
    assert (stall_cycles === e.sc) else begin
      miscompares++;
      $error("FAIL %s stall_cycles observed=%0d expected=%0d", e.tag, stall_cycles, e.sc);
    end
    vectors++;
    assert (flush_events === e.fe) else begin
      miscompares++;
      $error("FAIL %s flush_events observed=%0d expected=%0d", e.tag, flush_events, e.fe);
    end
  endtask

  // Inputs for the current cycle are already driven; queue the expectation, then compare.
  task automatic step(input string tag, input logic [8:0] pat, input logic [3:0] fwd,
                      input logic pe, input logic to);
    exp_t e;
    e.tag = tag;
    e.ctl = {pe, to, pat, fwd};
    e.sc  = sc_m;
    e.fe  = fe_m;
    sb.push_back(e);
    #1;
    check_out();
    if (pat[8]) sc_m = sc_m + 1;
    if (pat == BR) fe_m = fe_m + 1;
  endtask

  initial begin
    rst = 1'b1;
    quiet();

    @(negedge clk);
    step("reset", NONE, 4'b0000, 1'b0, 1'b0);

    // Fill: hazards, branch and memory wait all presented but suppressed
    @(negedge clk);
    rst = 1'b0;
    id_rs1 = 5'd5; id_rs1_used = 1'b1; ex_rf_wa = 5'd5; ex_rf_we = 1'b1; ex_is_load = 1'b1;
    ex_br_taken = 1'b1; mem_req = 1'b1;
    step("fill_edge0", NONE, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    quiet();
    step("fill_edge1", NONE, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    step("fill_done", NONE, 4'b0000, 1'b1, 1'b0);

    // Load-use
    @(negedge clk);
    id_rs1 = 5'd5; id_rs1_used = 1'b1; ex_rf_wa = 5'd5; ex_rf_we = 1'b1; ex_is_load = 1'b1;
    step("load_use", RAW, 4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    quiet();
    step("after_load_use", NONE, 4'b0000, 1'b1, 1'b0);

    // x0 and unused source never hazard
    @(negedge clk);
    id_rs1_used = 1'b1; ex_rf_we = 1'b1; ex_is_load = 1'b1;
    step("x0_src", NONE, 4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    quiet();
    id_rs2 = 5'd6; ex_rf_wa = 5'd6; ex_rf_we = 1'b1; ex_is_load = 1'b1;
    step("src_unused", NONE, 4'b0000, 1'b1, 1'b0);

    // WB-destination match: stall only when forwarding is absent
    @(negedge clk);
    quiet();
    id_rs2 = 5'd9; id_rs2_used = 1'b1; wb_rf_wa = 5'd9; wb_rf_we = 1'b1;
`ifdef HAZARD_FWD_EN
    step("wb_match", NONE, 4'b0000, 1'b1, 1'b0);
`else
    step("wb_match", RAW, 4'b0000, 1'b1, 1'b0);
`endif

    // Branch beats a simultaneous load-use
    @(negedge clk);
    quiet();
    id_rs1 = 5'd5; id_rs1_used = 1'b1; ex_rf_wa = 5'd5; ex_rf_we = 1'b1; ex_is_load = 1'b1;
    ex_br_taken = 1'b1;
    step("branch_raw", BR, 4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    quiet();
    step("after_branch", NONE, 4'b0000, 1'b1, 1'b0);

    // Memory wait with a held branch: flush deferred until mem_ready
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      quiet();
      mem_req = 1'b1; ex_br_taken = 1'b1;
      step("memwait_branch", MEMW, 4'b0000, 1'b1, 1'b0);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    step("mem_ready_branch", BR, 4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    quiet();
    step("after_memwait", NONE, 4'b0000, 1'b1, 1'b0);

    // Timeout after 64 wait cycles, sticky after release
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      quiet();
      mem_req = 1'b1;
      step("timeout_wait", MEMW, 4'b0000, 1'b1, 1'b0);
    end
    @(negedge clk);
    mem_req = 1'b1; mem_ready = 1'b1;
    step("timeout_release", NONE, 4'b0000, 1'b1, 1'b1);
    @(negedge clk);
    quiet();
    step("timeout_sticky", NONE, 4'b0000, 1'b1, 1'b1);

    // Forwarding selects
    @(negedge clk);
    quiet();
    ex_rs2 = 5'd7; mem_rf_wa = 5'd7; mem_rf_we = 1'b1; wb_rf_wa = 5'd7; wb_rf_we = 1'b1;
`ifdef HAZARD_FWD_EN
    step("fwd_exmem", NONE, 4'b0001, 1'b1, 1'b1);
`else
    step("fwd_exmem", NONE, 4'b0000, 1'b1, 1'b1);
`endif
    @(negedge clk);
    mem_rf_we = 1'b0;
`ifdef HAZARD_FWD_EN
    step("fwd_memwb", NONE, 4'b0010, 1'b1, 1'b1);
`else
    step("fwd_memwb", NONE, 4'b0000, 1'b1, 1'b1);
`endif
    @(negedge clk);
    ex_rs2 = 5'd0; ex_rs1 = 5'd7; mem_rf_we = 1'b1;
`ifdef HAZARD_FWD_EN
    step("fwd_rs1_x0_rs2", NONE, 4'b0100, 1'b1, 1'b1);
`else
    step("fwd_rs1_x0_rs2", NONE, 4'b0000, 1'b1, 1'b1);
`endif

    // Mid-operation reset clears everything and restarts the fill
    @(negedge clk);
    quiet();
    mem_req = 1'b1;
    rst = 1'b1;
    sc_m = 0;
    fe_m = 0;
    step("rst_mid", NONE, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    quiet();
    rst = 1'b0;
    step("refill_edge0", NONE, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    step("refill_edge1", NONE, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    step("refill_done", NONE, 4'b0000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
